pwm_from_counter: RTL and testbench

//  Downstream consumer of the free-running N-bit counter (count/done outputs).

---
 rtl/pwm_from_counter_if.sv | 21 ++
 rtl/pwm_from_counter.sv | 100 ++++++++++
 tb/tb_pwm_from_counter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_from_counter_if.sv
// Duty-word handshake between a duty source (master) and the PWM generator (slave).
// duty is N+1 bits wide so the full-on value 2^N is representable.
interface pwm_from_counter_if #(
   parameter int N = 4
);
   logic         duty_valid;
   logic [N:0]   duty;
   logic         duty_ready;

   modport master (
      output duty_valid,
      output duty,
      input  duty_ready
   );

   modport slave (
      input  duty_valid,
      input  duty,
      output duty_ready
   );
endinterface

// File: rtl/pwm_from_counter.sv
// PWM generator driven by a free-running N-bit counter; duty updates are
// double-buffered so a new value only takes effect at a period boundary.
module pwm_from_counter #(
   parameter int N      = 4,
   parameter int PCNT_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N-1:0]        count,
   input  logic                done,
   input  logic                en,
   pwm_from_counter_if.slave   duty_if,
   output logic                pwm,
   output logic                period_tick,
   output logic [PCNT_W-1:0]   period_cnt
);

   localparam logic [N:0] DUTY_MAX = {1'b1, {N{1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      RUN
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [N:0]    active_duty;
   logic [N:0]    pending_duty;
   logic          pending_full;
   logic          accept;
   logic [N:0]    duty_sat;
   logic          run_active;

   function automatic logic [N:0] clamp_duty(input logic [N:0] d);
      return (d > DUTY_MAX) ? DUTY_MAX : d;
   endfunction

   assign duty_if.duty_ready = !pending_full;
   assign accept             = duty_if.duty_valid && !pending_full;
   assign duty_sat           = clamp_duty(duty_if.duty);
   // Gating with en makes pwm drop on the very edge that sees en low.
   assign run_active         = (state == RUN) && en;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (!en) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    state_nxt = ARM;
            ARM:     if (done) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Pending and accept are mutually exclusive because ready = !pending_full.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         active_duty  <= '0;
         pending_duty <= '0;
         pending_full <= 1'b0;
      end else if (done && pending_full) begin
         active_duty  <= pending_duty;
         pending_full <= 1'b0;
      end else if (accept) begin
         if (done) begin
            active_duty <= duty_sat;
         end else begin
            pending_duty <= duty_sat;
            pending_full <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pwm         <= 1'b0;
         period_tick <= 1'b0;
         period_cnt  <= '0;
      end else begin
         pwm         <= run_active && ({1'b0, count} < active_duty);
         period_tick <= run_active && done;
         if (run_active && done) begin
            period_cnt <= period_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pwm_from_counter.sv
// Directed bench for pwm_from_counter: an 8-bit and a 2-bit period counter
// instance share the same stimulus from a bench-modelled 4-bit counter.
module tb_pwm_from_counter;

   localparam int N = 4;

   logic          clk;
   logic          reset;
   logic [N-1:0]  count;
   logic          done;
   logic          en;
   logic          pwm_a, tick_a, pwm_b, tick_b;
   logic [7:0]    cnt_a;
   logic [1:0]    cnt_b;
   int            n_assert;
   int            n_fail;

   pwm_from_counter_if #(.N(N)) ifa ();
   pwm_from_counter_if #(.N(N)) ifb ();

   pwm_from_counter #(.N(N), .PCNT_W(8)) dut_a (
      .clk         (clk),
      .reset       (reset),
      .count       (count),
      .done        (done),
      .en          (en),
      .duty_if     (ifa),
      .pwm         (pwm_a),
      .period_tick (tick_a),
      .period_cnt  (cnt_a)
   );

   pwm_from_counter #(.N(N), .PCNT_W(2)) dut_b (
      .clk         (clk),
      .reset       (reset),
      .count       (count),
      .done        (done),
      .en          (en),
      .duty_if     (ifb),
      .pwm         (pwm_b),
      .period_tick (tick_b),
      .period_cnt  (cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: outputs settle #1 after the edge, then the counter advances.
   task automatic tick();
      @(posedge clk);
      #1;
      count = count + 4'd1;
      done  = (count == 4'd15);
   endtask

   task automatic offer(input logic v, input logic [N:0] d);
      ifa.duty_valid = v;
      ifa.duty       = d;
      ifb.duty_valid = v;
      ifb.duty       = d;
   endtask

   task automatic run_to(input int target);
      int guard;
      guard = 0;
      while (int'(count) != target && guard < 32) begin
         tick();
         guard++;
      end
      if (int'(count) != target) chk("run_to_timeout", count, target);
   endtask

   task automatic check_cycles(input string tag, input int d, input int n);
      for (int i = 0; i < n; i++) begin
         int c;
         c = int'(count);
         tick();
         chk(tag, pwm_a, (c < d));
         chk({tag, "_b"}, pwm_b, (c < d));
         chk({tag, "_tick"}, tick_a, (c == 15));
      end
   endtask

   // Queue d into pending mid-period; it becomes active on the closing done edge.
   task automatic load_next(input logic [N:0] d);
      run_to(3);
      offer(1'b1, d);
      tick();
      offer(1'b0, d);
      chk("load_ready_low", ifa.duty_ready, 0);
      run_to(15);
      tick();
      chk("load_ready_high", ifa.duty_ready, 1);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      reset    = 1'b0;
      en       = 1'b0;
      count    = '0;
      done     = 1'b0;
      offer(1'b0, '0);

      #2;
      chk("rst_pwm", pwm_a, 0);
      chk("rst_tick", tick_a, 0);
      chk("rst_cnt", cnt_a, 0);
      chk("rst_ready", ifa.duty_ready, 1);
      #1 reset = 1'b1;

      // T2 basic: duty 4, five periods; 2-bit counter wraps 1,2,3,0,1
      run_to(3);
      offer(1'b1, 5'd4);
      tick();
      offer(1'b0, 5'd4);
      chk("t2_ready_pending", ifa.duty_ready, 0);
      en = 1'b1;
      tick();
      chk("t2_arm_pwm", pwm_a, 0);
      run_to(15);
      tick();
      chk("t2_ready_after_done", ifa.duty_ready, 1);
      chk("t2_first_done_pwm", pwm_a, 0);
      chk("t2_first_done_tick", tick_a, 0);
      chk("t2_cnt0", cnt_a, 0);
      for (int p = 1; p <= 5; p++) begin
         check_cycles("t2_pwm", 4, 16);
         chk("t2_cnt_a", cnt_a, p);
         chk("t6_cnt_b", cnt_b, p % 4);
      end

      // T4 update: 12 queued mid-period, 8 offered and held off until the boundary
      check_cycles("t4_pre", 4, 5);
      offer(1'b1, 5'd12);
      tick();
      chk("t4_pwm_c5", pwm_a, 0);
      offer(1'b1, 5'd8);
      chk("t4_ready_low", ifa.duty_ready, 0);
      check_cycles("t4_keep4", 4, 10);
      chk("t4_ready_at_boundary", ifa.duty_ready, 1);
      chk("t4_cnt6", cnt_a, 6);
      tick();
      chk("t4_pwm_c0", pwm_a, 1);
      offer(1'b0, 5'd8);
      chk("t4_8_accepted", ifa.duty_ready, 0);
      check_cycles("t4_use12", 12, 15);
      check_cycles("t4_use8", 8, 16);
      chk("t4_cnt8", cnt_a, 8);

      // T3 bounds, plus a direct-to-active load on a done edge
      load_next(5'd0);
      check_cycles("t3_duty0", 0, 16);
      load_next(5'd16);
      check_cycles("t3_duty16", 16, 16);
      run_to(15);
      offer(1'b1, 5'd2);
      tick();
      offer(1'b0, 5'd2);
      chk("t3_direct_ready", ifa.duty_ready, 1);
      check_cycles("t3_direct2", 2, 16);
      load_next(5'd20);
      check_cycles("t3_duty20", 16, 16);
      chk("t3_cnt16", cnt_a, 16);

      // T5 enable: drop en mid-period, re-arm, restart only after a done edge
      run_to(5);
      en = 1'b0;
      tick();
      chk("t5_pwm_off", pwm_a, 0);
      run_to(15);
      tick();
      chk("t5_no_tick", tick_a, 0);
      chk("t5_cnt_hold", cnt_a, 16);
      chk("t5_cnt_b_hold", cnt_b, 0);
      run_to(8);
      en = 1'b1;
      tick();
      chk("t5_arm_pwm", pwm_a, 0);
      run_to(15);
      tick();
      chk("t5_boundary_pwm", pwm_a, 0);
      chk("t5_boundary_tick", tick_a, 0);
      chk("t5_cnt_still", cnt_a, 16);
      tick();
      chk("t5_restart_pwm", pwm_a, 1);

      // T1 asynchronous reset mid-RUN with pwm high and pending full
      offer(1'b1, 5'd4);
      tick();
      offer(1'b0, 5'd4);
      chk("t1_pre_pwm", pwm_a, 1);
      chk("t1_pre_ready", ifa.duty_ready, 0);
      reset = 1'b0;
      #2;
      chk("t1_pwm", pwm_a, 0);
      chk("t1_cnt", cnt_a, 0);
      chk("t1_ready", ifa.duty_ready, 1);
      chk("t1_tick", tick_a, 0);
      #1 reset = 1'b1;
      tick();
      chk("t1_after_pwm", pwm_a, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
